// File: rtl/vector_to_axis_packet.sv
// Serialises a held byte vector into an AXI-Stream packet of aligned beats.
// Define VECTOR_TO_AXIS_PACKET_REPEAT_EN to add the repeat_mode input.
module vector_to_axis_packet #(
    parameter int VEC_BYTES  = 8,
    parameter int AXIS_BYTES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                           clk,
    input  logic                           sresetn,
    input  logic [VEC_BYTES*8-1:0]         vec,
    input  logic [$clog2(VEC_BYTES+1)-1:0] vec_len,
    input  logic                           vec_valid,
    output logic                           vec_ready,
`ifdef VECTOR_TO_AXIS_PACKET_REPEAT_EN
    input  logic                           repeat_mode,
`endif
    output logic                           axis_tvalid,
    input  logic                           axis_tready,
    output logic [AXIS_BYTES*8-1:0]        axis_tdata,
    output logic [AXIS_BYTES-1:0]          axis_tkeep,
    output logic                           axis_tlast
);

    localparam int LW = $clog2(VEC_BYTES + 1);
    localparam int NS = VEC_BYTES / AXIS_BYTES;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] TOP_SLICE = CW'(NS - 1);

    if (VEC_BYTES % AXIS_BYTES != 0) begin : g_bad_cfg
        $error("VEC_BYTES must be a multiple of AXIS_BYTES");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [CW-1:0]          beat;
    logic [CW-1:0]          beat_n;
    logic [CW-1:0]          slice;
    logic [VEC_BYTES*8-1:0] hold_vec;
    logic [LW-1:0]          hold_len;
    logic [LW-1:0]          eff_len;
    logic                   fire;
    logic                   last_fire;
    logic                   capture;
    logic                   is_last;
    logic                   rpt;
    int                     nbeats;
    int                     rem;

`ifdef VECTOR_TO_AXIS_PACKET_REPEAT_EN
    assign rpt = repeat_mode;
`else
    assign rpt = 1'b0;
`endif

    // Zero or oversized lengths mean "whole vector".
    assign eff_len = (vec_len == '0 || int'(vec_len) > VEC_BYTES)
                   ? LW'(VEC_BYTES) : vec_len;

    always_comb begin
        nbeats = (int'(hold_len) + AXIS_BYTES - 1) / AXIS_BYTES;
        rem    = int'(hold_len) % AXIS_BYTES;
    end

    assign is_last     = (int'(beat) == nbeats - 1);
    assign axis_tvalid = sresetn && (state == SEND);
    assign axis_tlast  = axis_tvalid && is_last;
    assign fire        = axis_tvalid && axis_tready;
    assign last_fire   = fire && axis_tlast;
    assign vec_ready   = sresetn && ((state == IDLE) || last_fire);
    assign capture     = vec_valid && vec_ready;
    assign slice       = MSB_FIRST ? (TOP_SLICE - beat) : beat;

    always_comb begin
        axis_tdata = '0;
        axis_tkeep = '0;
        if (axis_tvalid) begin
            axis_tdata = hold_vec[int'(slice)*AXIS_BYTES*8 +: AXIS_BYTES*8];
            axis_tkeep = '1;
            if (is_last && rem != 0) begin
                for (int i = 0; i < AXIS_BYTES; i++) begin
                    axis_tkeep[i] = MSB_FIRST ? (i >= AXIS_BYTES - rem)
                                              : (i < rem);
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        beat_n  = beat;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    state_n = SEND;
                    beat_n  = '0;
                end
            end
            SEND: begin
                if (capture) begin
                    beat_n = '0;
                end else if (last_fire) begin
                    state_n = rpt ? SEND : IDLE;
                    beat_n  = '0;
                end else if (fire) begin
                    beat_n = beat + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                beat_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state    <= IDLE;
            beat     <= '0;
            hold_vec <= '0;
            hold_len <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            if (capture) begin
                hold_vec <= vec;
                hold_len <= eff_len;
            end
        end
    end

endmodule

// File: tb/tb_vector_to_axis_packet.sv
// Directed bench: byte-wide LSB-first and 4-byte MSB-first serialisers.
module tb_vector_to_axis_packet;

    logic        clk;
    logic        sresetn;

    logic [31:0] a_vec;
    logic [2:0]  a_len;
    logic        a_vv;
    logic        a_vr;
    logic        a_tv;
    logic        a_tr;
    logic [7:0]  a_td;
    logic [0:0]  a_tk;
    logic        a_tl;
`ifdef VECTOR_TO_AXIS_PACKET_REPEAT_EN
    logic        a_rep;
    logic        b_rep;
`endif

    logic [63:0] b_vec;
    logic [3:0]  b_len;
    logic        b_vv;
    logic        b_vr;
    logic        b_tv;
    logic        b_tr;
    logic [31:0] b_td;
    logic [3:0]  b_tk;
    logic        b_tl;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] TR_PAT = 6'b110010;

    vector_to_axis_packet #(
        .VEC_BYTES (4),
        .AXIS_BYTES(1),
        .MSB_FIRST (1'b0)
    ) u_a (
        .clk        (clk),
        .sresetn    (sresetn),
        .vec        (a_vec),
        .vec_len    (a_len),
        .vec_valid  (a_vv),
        .vec_ready  (a_vr),
`ifdef VECTOR_TO_AXIS_PACKET_REPEAT_EN
        .repeat_mode(a_rep),
`endif
        .axis_tvalid(a_tv),
        .axis_tready(a_tr),
        .axis_tdata (a_td),
        .axis_tkeep (a_tk),
        .axis_tlast (a_tl)
    );

    vector_to_axis_packet #(
        .VEC_BYTES (8),
        .AXIS_BYTES(4),
        .MSB_FIRST (1'b1)
    ) u_b (
        .clk        (clk),
        .sresetn    (sresetn),
        .vec        (b_vec),
        .vec_len    (b_len),
        .vec_valid  (b_vv),
        .vec_ready  (b_vr),
`ifdef VECTOR_TO_AXIS_PACKET_REPEAT_EN
        .repeat_mode(b_rep),
`endif
        .axis_tvalid(b_tv),
        .axis_tready(b_tr),
        .axis_tdata (b_td),
        .axis_tkeep (b_tk),
        .axis_tlast (b_tl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sresetn = 1'b0;
        a_vec = '0; a_len = '0; a_vv = 1'b0; a_tr = 1'b1;
        b_vec = '0; b_len = '0; b_vv = 1'b0; b_tr = 1'b1;
`ifdef VECTOR_TO_AXIS_PACKET_REPEAT_EN
        a_rep = 1'b0;
        b_rep = 1'b0;
`endif
        tick();
        tick();
        #1;
        chk("rst_a_vr", 64'(a_vr), 64'd0);
        chk("rst_a_tv", 64'(a_tv), 64'd0);
        chk("rst_a_tl", 64'(a_tl), 64'd0);
        chk("rst_a_td", 64'(a_td), 64'd0);
        chk("rst_b_vr", 64'(b_vr), 64'd0);
        chk("rst_b_tk", 64'(b_tk), 64'd0);
        sresetn = 1'b1;
        #1;
        chk("rel_a_vr", 64'(a_vr), 64'd1);
        chk("rel_a_tv", 64'(a_tv), 64'd0);

        // Four single-byte beats, ascending.
        a_vec = 32'h44332211; a_len = 3'd4; a_vv = 1'b1;
        tick();
        a_vv = 1'b0; a_vec = 32'hDEADBEEF; a_len = 3'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("p1_tv", 64'(a_tv), 64'd1);
            chk("p1_td", 64'(a_td), 64'((i + 1) * 8'h11));
            chk("p1_tk", 64'(a_tk), 64'd1);
            chk("p1_tl", 64'(a_tl), 64'(i == 3));
            chk("p1_vr", 64'(a_vr), 64'(i == 3));
            tick();
        end
        #1;
        chk("p1_end_tv", 64'(a_tv), 64'd0);
        chk("p1_end_td", 64'(a_td), 64'd0);
        chk("p1_end_vr", 64'(a_vr), 64'd1);

        // len=3 with tready stalls.
        a_vec = 32'hDDCCBBAA; a_len = 3'd3; a_vv = 1'b1;
        tick();
        a_vv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_tr = TR_PAT[i];
            #1;
            chk("st_tv", 64'(a_tv), 64'd1);
            chk("st_td", 64'(a_td),
                (i < 2) ? 64'hAA : (i < 5) ? 64'hBB : 64'hCC);
            chk("st_tl", 64'(a_tl), 64'(i == 5));
            chk("st_vr", 64'(a_vr), 64'(i == 5));
            tick();
        end
        a_tr = 1'b1;
        #1;
        chk("st_end_tv", 64'(a_tv), 64'd0);

        // Back-to-back: second vector (len=0 -> 4) offered on final beat.
        a_vec = 32'h04030201; a_len = 3'd2; a_vv = 1'b1;
        tick();
        a_vv = 1'b0;
        #1;
        chk("bb_td0", 64'(a_td), 64'h01);
        chk("bb_tl0", 64'(a_tl), 64'd0);
        tick();
        a_vv = 1'b1; a_vec = 32'h08070605; a_len = 3'd0;
        #1;
        chk("bb_td1", 64'(a_td), 64'h02);
        chk("bb_tl1", 64'(a_tl), 64'd1);
        chk("bb_vr1", 64'(a_vr), 64'd1);
        tick();
        a_vv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bb2_tv", 64'(a_tv), 64'd1);
            chk("bb2_td", 64'(a_td), 64'(8'h05 + i));
            chk("bb2_tl", 64'(a_tl), 64'(i == 3));
            tick();
        end
        #1;
        chk("bb2_end_tv", 64'(a_tv), 64'd0);

        // Reset during second of four beats (len=7 -> 4).
        a_vec = 32'hA4A3A2A1; a_len = 3'd7; a_vv = 1'b1;
        tick();
        a_vv = 1'b0;
        #1;
        chk("rm_td0", 64'(a_td), 64'hA1);
        tick();
        #1;
        chk("rm_td1", 64'(a_td), 64'hA2);
        sresetn = 1'b0;
        #1;
        chk("rm_in_tv", 64'(a_tv), 64'd0);
        chk("rm_in_vr", 64'(a_vr), 64'd0);
        tick();
        #1;
        chk("rm_nx_tv", 64'(a_tv), 64'd0);
        chk("rm_nx_tl", 64'(a_tl), 64'd0);
        chk("rm_nx_td", 64'(a_td), 64'd0);
        sresetn = 1'b1;
        #1;
        chk("rm_rel_vr", 64'(a_vr), 64'd1);
        tick();
        #1;
        chk("rm_post_tv", 64'(a_tv), 64'd0);
        tick();
        #1;
        chk("rm_post2_tv", 64'(a_tv), 64'd0);

        // MSB-first, 4-byte beats, len=6.
        b_vec = 64'h8877665544332211; b_len = 4'd6; b_vv = 1'b1;
        tick();
        b_vv = 1'b0;
        #1;
        chk("m6_td0", 64'(b_td), 64'h88776655);
        chk("m6_tk0", 64'(b_tk), 64'hF);
        chk("m6_tl0", 64'(b_tl), 64'd0);
        tick();
        #1;
        chk("m6_td1", 64'(b_td), 64'h44332211);
        chk("m6_tk1", 64'(b_tk), 64'hC);
        chk("m6_tl1", 64'(b_tl), 64'd1);
        chk("m6_vr1", 64'(b_vr), 64'd1);
        tick();
        #1;
        chk("m6_end_tv", 64'(b_tv), 64'd0);
        chk("m6_end_tk", 64'(b_tk), 64'd0);

        // len=3: single partial beat, held through a stall.
        b_len = 4'd3; b_vv = 1'b1;
        tick();
        b_vv = 1'b0; b_tr = 1'b0; b_vec = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("m3_td", 64'(b_td), 64'h88776655);
            chk("m3_tk", 64'(b_tk), 64'hE);
            chk("m3_tl", 64'(b_tl), 64'd1);
            chk("m3_vr", 64'(b_vr), 64'd0);
            tick();
        end
        b_tr = 1'b1;
        #1;
        chk("m3_acc_vr", 64'(b_vr), 64'd1);
        tick();
        #1;
        chk("m3_end_tv", 64'(b_tv), 64'd0);

        // len=9 clamps to 8: two full beats.
        b_vec = 64'h0123456789ABCDEF; b_len = 4'd9; b_vv = 1'b1;
        tick();
        b_vv = 1'b0;
        #1;
        chk("m9_td0", 64'(b_td), 64'h01234567);
        chk("m9_tk0", 64'(b_tk), 64'hF);
        tick();
        #1;
        chk("m9_td1", 64'(b_td), 64'h89ABCDEF);
        chk("m9_tk1", 64'(b_tk), 64'hF);
        chk("m9_tl1", 64'(b_tl), 64'd1);
        tick();
        #1;
        chk("m9_end_tv", 64'(b_tv), 64'd0);

`ifdef VECTOR_TO_AXIS_PACKET_REPEAT_EN
        a_vec = 32'h00002211; a_len = 3'd2; a_vv = 1'b1; a_rep = 1'b1;
        tick();
        a_vv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) a_rep = 1'b0;
            #1;
            chk("rp_tv", 64'(a_tv), 64'd1);
            chk("rp_td", 64'(a_td), (i % 2 == 0) ? 64'h11 : 64'h22);
            chk("rp_tl", 64'(a_tl), 64'(i % 2 == 1));
            tick();
        end
        #1;
        chk("rp_end_tv", 64'(a_tv), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
